// File: rtl/mmul_seq_if.sv
// Host stream port of the modular-multiplier sequencer.
// Operands flow host->sequencer, results sequencer->host.
interface mmul_seq_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/mmul_seq.sv
// Host-side sequencer: loads A/B/P into the multiplier core,
// runs it with a timeout, then unloads the selected result.
module mmul_seq #(
  parameter int WORDS = 16,
  parameter int DW    = 16,
  parameter int TMO   = 4095
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    res_sel,
  mmul_seq_if.slave     host,
  output logic [DW-1:0] mm_datain,
  output logic          mm_loada,
  output logic          mm_loadb,
  output logic          mm_loadp,
  output logic          mm_en,
  output logic          mm_outc,
  output logic          mm_outd,
  output logic          mm_outb,
  input  logic          mm_rdy,
  input  logic [DW-1:0] mm_regcout,
  input  logic [DW-1:0] mm_regdout,
  input  logic [DW-1:0] mm_regbout,
  input  logic [1:0]    mm_cflag,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    cflag
);

  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(WORDS - 1);
  localparam logic [11:0]   T_LAST = 12'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE, LDA, LDB, LDP, RUN, UNLD, DONE
  } state_t;

  state_t        state, state_n;
  logic [WW-1:0] wcnt, wcnt_n, wcnt_inc;
  logic [11:0]   tcnt, tcnt_n;
  logic [1:0]    sel, sel_n, cflag_n;
  logic          err_n, w_last;
  logic          sel_c, sel_d, sel_b;

  assign w_last   = (wcnt == W_LAST);
  assign wcnt_inc = w_last ? '0 : wcnt + 1'b1;
  assign busy     = (state != IDLE);

  // Reserved select code falls back to C.
  always_comb begin
    sel_c = 1'b0;
    sel_d = 1'b0;
    sel_b = 1'b0;
    unique case (1'b1)
      (sel == 2'd1): sel_d = 1'b1;
      (sel == 2'd2): sel_b = 1'b1;
      default:       sel_c = 1'b1;
    endcase
  end

  always_comb begin
    host.out_data = mm_regcout;
    if (sel_d) host.out_data = mm_regdout;
    if (sel_b) host.out_data = mm_regbout;
  end

  always_comb begin
    state_n        = state;
    wcnt_n         = wcnt;
    tcnt_n         = tcnt;
    sel_n          = sel;
    err_n          = err;
    cflag_n        = cflag;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    mm_datain      = '0;
    mm_loada       = 1'b0;
    mm_loadb       = 1'b0;
    mm_loadp       = 1'b0;
    mm_en          = 1'b0;
    mm_outc        = 1'b0;
    mm_outd        = 1'b0;
    mm_outb        = 1'b0;
    done           = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          sel_n   = res_sel;
          err_n   = 1'b0;
          wcnt_n  = '0;
          state_n = LDA;
        end
      end
      LDA, LDB, LDP: begin
        host.in_ready = 1'b1;
        mm_datain     = host.in_data;
        mm_loada      = (state == LDA) && host.in_valid;
        mm_loadb      = (state == LDB) && host.in_valid;
        mm_loadp      = (state == LDP) && host.in_valid;
        if (host.in_valid) begin
          wcnt_n = wcnt_inc;
          if (w_last) begin
            tcnt_n  = '0;
            state_n = (state == LDA) ? LDB :
                      (state == LDB) ? LDP : RUN;
          end
        end
      end
      RUN: begin
        mm_en  = 1'b1;
        tcnt_n = tcnt + 12'd1;
        if (mm_rdy) begin
          cflag_n = mm_cflag;
          wcnt_n  = '0;
          state_n = UNLD;
        end else if (tcnt == T_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      UNLD: begin
        host.out_valid = 1'b1;
        if (host.out_ready) begin
          mm_outc = sel_c;
          mm_outd = sel_d;
          mm_outb = sel_b;
          wcnt_n  = wcnt_inc;
          if (w_last) state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
      tcnt  <= '0;
      sel   <= '0;
      err   <= 1'b0;
      cflag <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      tcnt  <= tcnt_n;
      sel   <= sel_n;
      err   <= err_n;
      cflag <= cflag_n;
    end
  end

endmodule

// File: tb/tb_mmul_seq.sv
// Randomized bench for mmul_seq with a stub multiplier core.
// Expected streams come from plain arrays, not from the RTL.
module tb_mmul_seq;
  localparam int W   = 16;
  localparam int DW  = 16;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    res_sel = 2'd0;
  logic [DW-1:0] mm_datain, regc, regd, regb;
  logic          mm_loada, mm_loadb, mm_loadp, mm_en;
  logic          mm_outc, mm_outd, mm_outb, mm_rdy;
  logic          busy, done, err;
  logic [1:0]    mm_cflag = 2'd0;
  logic [1:0]    cflag;

  mmul_seq_if #(.DW(DW)) bus ();

  mmul_seq #(.WORDS(W), .DW(DW), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .res_sel    (res_sel),
    .host       (bus),
    .mm_datain  (mm_datain),
    .mm_loada   (mm_loada),
    .mm_loadb   (mm_loadb),
    .mm_loadp   (mm_loadp),
    .mm_en      (mm_en),
    .mm_outc    (mm_outc),
    .mm_outd    (mm_outd),
    .mm_outb    (mm_outb),
    .mm_rdy     (mm_rdy),
    .mm_regcout (regc),
    .mm_regdout (regd),
    .mm_regbout (regb),
    .mm_cflag   (mm_cflag),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cflag      (cflag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stub core: result registers shift on out strobes
  logic [DW-1:0] ws [3*W];
  logic [DW-1:0] cw [W];
  logic [DW-1:0] dw [W];
  logic [DW-1:0] bw [W];
  int ci = 0, di = 0, bi = 0, en_cnt = 0, rdy_at = 0;

  always @(posedge clk) begin
    if (start) begin
      ci <= 0;
      di <= 0;
      bi <= 0;
    end else begin
      if (mm_outc) ci <= ci + 1;
      if (mm_outd) di <= di + 1;
      if (mm_outb) bi <= bi + 1;
    end
    en_cnt <= mm_en ? en_cnt + 1 : 0;
  end

  assign regc   = cw[ci % W];
  assign regd   = dw[di % W];
  assign regb   = bw[bi % W];
  assign mm_rdy = mm_en && (rdy_at > 0) && (en_cnt == rdy_at - 1);

  function automatic logic [DW-1:0] exp_word(input logic [1:0] s,
                                             input int i);
    case (s)
      2'd1:    return dw[i];
      2'd2:    return bw[i];
      default: return cw[i];
    endcase
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 3*W; i++) ws[i] = DW'($urandom);
    for (int i = 0; i < W; i++) begin
      cw[i] = DW'($urandom);
      dw[i] = DW'($urandom);
      bw[i] = DW'($urandom);
    end
  endtask

  // lat = core latency in RUN cycles; 0 means the core never finishes
  task automatic run_op(input string nm, input logic [1:0] sel,
                        input int lat, input bit bp);
    logic [DW-1:0] la[$], lb[$], lp[$], lo[$];
    int  noc, nod, nob, en_c, ov_c, dn, viol, ordv, idx;
    int  cyc, last_hs, done_cyc, end_cyc, bw_cnt;
    bit  fin, to;
    logic [1:0] cf;
    noc = 0; nod = 0; nob = 0; en_c = 0; ov_c = 0; dn = 0;
    viol = 0; ordv = 0; idx = 0; bw_cnt = 0;
    last_hs = -1; done_cyc = -1; end_cyc = -1; fin = 0;
    to = (lat == 0) || (lat > TMO);
    cf = ~cflag;
    mm_cflag = cf;
    rdy_at = lat;
    @(posedge clk); #1;
    start = 1'b1;
    res_sel = sel;
    for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      res_sel = 2'($urandom);
      bus.in_valid = (idx < 3*W) && (!bp || (cyc % 2 == 1));
      bus.in_data = (idx < 3*W) ? ws[idx] : DW'($urandom);
      bus.out_ready = !bp || (cyc % 2 == 0);
      @(negedge clk);
      if (cyc == 0) chk({nm, " errclr"}, err, 0);
      if (bus.in_valid && bus.in_ready) idx++;
      if ($countones({mm_loada, mm_loadb, mm_loadp,
                      mm_outc, mm_outd, mm_outb}) > 1) viol++;
      if ((mm_loada | mm_loadb | mm_loadp) !=
          (bus.in_valid & bus.in_ready)) viol++;
      if ((mm_outc | mm_outd | mm_outb) !=
          (bus.out_valid & bus.out_ready)) viol++;
      if (!bus.in_ready && mm_datain != '0) viol++;
      if (mm_loada) begin
        if (lb.size() + lp.size() != 0) ordv++;
        la.push_back(mm_datain);
      end
      if (mm_loadb) begin
        if (la.size() != W || lp.size() != 0) ordv++;
        lb.push_back(mm_datain);
      end
      if (mm_loadp) begin
        if (lb.size() != W) ordv++;
        lp.push_back(mm_datain);
      end
      if (mm_outc) noc++;
      if (mm_outd) nod++;
      if (mm_outb) nob++;
      if (bus.out_valid && bus.out_ready) begin
        lo.push_back(bus.out_data);
        last_hs = cyc;
      end
      if (bus.out_valid) ov_c++;
      if (mm_en) begin
        en_c++;
        if (en_c == 5) start = 1'b1;
      end
      if (done) begin
        dn++;
        done_cyc = cyc;
        start = 1'b1;
      end
      if (!busy) begin
        fin = 1;
        end_cyc = cyc;
      end
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk({nm, " finish"}, 32'(fin), 1);
    chk({nm, " viol"}, viol, 0);
    chk({nm, " order"}, ordv, 0);
    chk({nm, " nA"}, la.size(), W);
    chk({nm, " nB"}, lb.size(), W);
    chk({nm, " nP"}, lp.size(), W);
    for (int i = 0; i < W; i++) begin
      if (i < la.size() && la[i] !== ws[i]) bw_cnt++;
      if (i < lb.size() && lb[i] !== ws[W+i]) bw_cnt++;
      if (i < lp.size() && lp[i] !== ws[2*W+i]) bw_cnt++;
    end
    chk({nm, " ld data"}, bw_cnt, 0);
    if (to) begin
      chk({nm, " en cyc"}, en_c, TMO);
      chk({nm, " err"}, err, 1);
      chk({nm, " out_valid"}, ov_c, 0);
      chk({nm, " done"}, dn, 0);
    end else begin
      chk({nm, " en cyc"}, en_c, lat);
      chk({nm, " err"}, err, 0);
      chk({nm, " cflag"}, cflag, cf);
      chk({nm, " nOut"}, lo.size(), W);
      bw_cnt = 0;
      for (int i = 0; i < W; i++)
        if (i < lo.size() && lo[i] !== exp_word(sel, i)) bw_cnt++;
      chk({nm, " out data"}, bw_cnt, 0);
      chk({nm, " outc"}, noc, (sel == 2'd0 || sel == 2'd3) ? W : 0);
      chk({nm, " outd"}, nod, (sel == 2'd1) ? W : 0);
      chk({nm, " outb"}, nob, (sel == 2'd2) ? W : 0);
      chk({nm, " done cnt"}, dn, 1);
      chk({nm, " done cyc"}, done_cyc, last_hs + 1);
      chk({nm, " idle cyc"}, end_cyc, done_cyc + 1);
    end
  endtask

  initial begin
    int nb, idx;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    fill_rand();
    #3;
    chk("rst busy", busy, 0);
    chk("rst strobes", {mm_loada, mm_loadb, mm_loadp, mm_en,
                        mm_outc, mm_outd, mm_outb, done}, 0);
    chk("rst ready", {bus.in_ready, bus.out_valid}, 0);
    chk("rst err", err, 0);
    chk("rst cflag", cflag, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < W; i++) begin
      ws[i]       = (i == 0) ? DW'(1) : '0;
      ws[W+i]     = (i == 0) ? DW'(2) : '0;
      ws[2*W+i]   = 16'hFFFF;
      cw[i]       = DW'(i + 1);
    end
    run_op("nom", 2'd0, 40, 1'b0);

    fill_rand();
    run_op("bp", 2'($urandom), $urandom_range(8, 60), 1'b1);
    fill_rand();
    run_op("selD", 2'd1, $urandom_range(8, 60), 1'($urandom));
    fill_rand();
    run_op("selB", 2'd2, $urandom_range(8, 60), 1'($urandom));
    fill_rand();
    run_op("selR", 2'd3, $urandom_range(8, 60), 1'($urandom));

    fill_rand();
    run_op("tmo", 2'd0, 0, 1'b0);
    fill_rand();
    run_op("race", 2'($urandom), TMO, 1'($urandom));

    fill_rand();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    nb = 0;
    bus.in_valid = 1'b1;
    bus.in_data = ws[0];
    for (int k = 0; k < 200 && nb < 7; k++) begin
      @(negedge clk);
      if (mm_loadb) nb++;
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
      bus.in_data = ws[idx];
    end
    chk("rstmid nb", nb, 7);
    #2;
    chk("rstmid pre", mm_loadb, 1);
    rst = 1'b0;
    #1;
    chk("rstmid strobes", {mm_loada, mm_loadb, mm_loadp, mm_en}, 0);
    chk("rstmid busy", busy, 0);
    chk("rstmid in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    fill_rand();
    run_op("postrst", 2'($urandom), $urandom_range(8, 60), 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_rand();
      run_op($sformatf("rnd%0d", r), 2'($urandom),
             $urandom_range(8, 99), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmul_seq.md
Name: mmul_seq

Overview:
Host-side sequencer for the 256-bit modular-multiplier core. It streams operand words A, B and P from a valid/ready host port into the core's load strobes, then runs the core until its ready flag rises. It then unloads the selected 16-word result register to a valid/ready output port under back-pressure. Timeouts and status are reported to the host. The block sits between the system bus adapter and the multiplier top.

Parameters:
WORDS, 16, words per operand/result (operand width = WORDS*DW)
DW, 16, word width
TMO, 4095, max cycles in RUN before timeout error (12-bit counter; TMO >= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  1-cycle command pulse; sampled only in IDLE
res_sel  in  2  result to unload: 0=C, 1=D, 2=B, 3=reserved (treated as C); latched on start
in_valid  in  1  host operand word valid
in_data  in  DW  host operand word
in_ready  out  1  sequencer accepts in_data this cycle
out_valid  out  1  result word valid
out_data  out  DW  result word
out_ready  in  1  host accepts out_data
mm_datain  out  DW  core data input
mm_loada, mm_loadb, mm_loadp  out  1  core operand shift-in strobes
mm_en  out  1  core run enable
mm_outc, mm_outd, mm_outb  out  1  core result shift strobes
mm_rdy  in  1  core completion flag
mm_regcout, mm_regdout, mm_regbout  in  DW  core result heads
mm_cflag  in  2  core carry flag
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at end of unload
err  out  1  sticky timeout flag; cleared on accepted start
cflag  out  2  mm_cflag captured when mm_rdy is seen

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE, word count=0, timeout count=0, err=0, cflag=0, done=0. All strobes and mm_en are 0. Outputs settle immediately, asynchronously.
- States: IDLE, LDA, LDB, LDP, RUN, UNLD, DONE. One word counter wcnt (log2 WORDS bits) is shared across states.
- IDLE: in_ready=0, out_valid=0. On start=1, latch res_sel, clear err, set wcnt=0 and go to LDA. The start pulse is ignored in every other state.
- LDA/LDB/LDP: in_ready=1. mm_datain=in_data, combinational. The load strobe for the current state equals in_valid, so one word is transferred per handshake cycle. Words are sent least-significant first. Each handshake increments wcnt. A handshake with wcnt=WORDS-1 wraps wcnt to 0 and advances LDA->LDB->LDP->RUN. When in_valid=0, nothing moves and the state holds indefinitely.
- At most one mm_load*/mm_out* strobe is high in any cycle. mm_datain=0 outside the load states.
- RUN: mm_en=1 (level). The timeout counter clears on entry and increments each cycle.
  - mm_rdy=1: capture cflag, set wcnt=0, go to UNLD. mm_en drops the next cycle.
  - The counter reaches TMO with mm_rdy=0: set err=1, go to IDLE. No unload and no done pulse occur.
  - mm_rdy and timeout in the same cycle: mm_rdy wins.
- UNLD: out_valid=1. out_data is the head of the selected register: C=mm_regcout, D=mm_regdout, B=mm_regbout. When out_ready=1, the matching mm_out* strobe is asserted the same cycle, the core shifts, and wcnt increments. Handshake with wcnt=WORDS-1 -> DONE. When out_ready=0, no strobe is asserted and out_data holds.
- DONE: done=1 for exactly 1 cycle, then IDLE. A start pulse in DONE is ignored.
- Throughput: with continuous valid/ready, the run takes 3*WORDS load cycles + core latency + 1 + WORDS unload cycles + 1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Nominal: start, res_sel=0; stream A=1, B=2, P=0x...FFFF (word 0 = 0xFFFF); stub core raises mm_rdy after 40 cycles with regcout sequence 0x0001..0x0010 -> exactly 16 loada, 16 loadb and 16 loadp pulses carrying the stream words in order; mm_en high 40 cycles; 16 outc pulses; out_data sequence 0x0001..0x0010; done pulse in the cycle after the last handshake; busy low one cycle later.
- Back-pressure: in_valid toggles 1,0,1,0 and out_ready is low on every other cycle -> load/out strobes occur only on handshake cycles; no word is dropped or duplicated; wcnt ends at 0.
- Result select: res_sel=1, then res_sel=2 runs -> only mm_outd and only mm_outb pulse respectively, 16 each; res_sel=3 behaves as C.
- Timeout: TMO=100, mm_rdy held at 0 -> err=1 after 100 RUN cycles, state IDLE, no out_valid, no done. The next start clears err.
- Reset mid-load: rst=0 asynchronously after 7 loadb words -> all strobes, busy and in_ready drop without waiting for a clock edge. After release, a fresh start begins at LDA with wcnt=0.
- Ignored start / race: start pulsed during RUN and during DONE -> no effect. With mm_rdy rising in the same cycle the counter hits TMO -> UNLD entered, err stays 0, and cflag equals mm_cflag (e.g. 2'b01).
